// File: rtl/riscv_wb_buffer.sv
// Writeback buffer between the execute/load units and the register-file write port.
// Results enter through a valid/ready handshake. They drain in order, one per cycle,
// through a combinational write port driven by the head entry. Decode can look up
// rs1/rs2 against results that have not yet been written and receive forwarded data.
//
// Handshake: a transfer completes on a rising edge where i_in_valid && o_in_ready.
// o_in_ready is !full and does not depend on i_in_valid. A completed transfer whose
// i_in_rd is x0 is accepted and dropped, because x0 is never written.
module riscv_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [4:0]      i_in_rd,
    input  logic [XLEN-1:0] i_in_data,
    output logic            o_reg_write_en,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_data_to_reg,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    output logic            o_rs1_pending,
    output logic            o_rs2_pending,
    output logic [XLEN-1:0] o_rs1_fwd_data,
    output logic [XLEN-1:0] o_rs2_fwd_data,
    output logic [CW-1:0]   o_count,
    output logic            o_empty,
    output logic            o_full
);

    logic [4:0]      r_mem_rd   [DEPTH];
    logic [XLEN-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    // The count register is the only source of full/empty; pointers just wrap.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // The x0 destination completes the handshake but never occupies a slot.
    assign w_push  = i_in_valid && !w_full && (i_in_rd != 5'd0);
    // The head is written at the falling edge and leaves at the next rising edge.
    assign w_pop   = !w_empty;

    assign o_in_ready = !w_full;
    assign o_count    = r_count;
    assign o_empty    = w_empty;
    assign o_full     = w_full;

    // Write port is a straight view of the head entry, zeroed when nothing is buffered.
    always_comb begin
        o_reg_write_en = 1'b0;
        o_rd           = 5'd0;
        o_data_to_reg  = '0;
        if (!w_empty) begin
            o_reg_write_en = 1'b1;
            o_rd           = r_mem_rd[r_rd_ptr];
            o_data_to_reg  = r_mem_data[r_rd_ptr];
        end
    end

    // Pointer and occupancy update; reset drops every buffered entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; only the slot at the write pointer changes on a push.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= i_in_rd;
            r_mem_data[r_wr_ptr] <= i_in_data;
        end
    end

    // Source lookup walks oldest to youngest so the youngest match is the one that sticks.
    // The head is still visible in the cycle it is being written.
    always_comb begin
        logic [PW-1:0] w_idx;
        o_rs1_pending  = 1'b0;
        o_rs2_pending  = 1'b0;
        o_rs1_fwd_data = '0;
        o_rs2_fwd_data = '0;
        w_idx          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PW'(i);
            if (CW'(i) < r_count) begin
                if ((i_rs1 != 5'd0) && (r_mem_rd[w_idx] == i_rs1)) begin
                    o_rs1_pending  = 1'b1;
                    o_rs1_fwd_data = r_mem_data[w_idx];
                end
                if ((i_rs2 != 5'd0) && (r_mem_rd[w_idx] == i_rs2)) begin
                    o_rs2_pending  = 1'b1;
                    o_rs2_fwd_data = r_mem_data[w_idx];
                end
            end
        end
    end

endmodule
